// File: rtl/conv_window_addr_gen.sv
// Sliding-window address generator: scans a row-major IMG_H x IMG_W map with a KxK window.
// Define CONV_WINDOW_ZERO_PAD_EN for "same" zero padding (pad flag, addr forced to 0 off-map).
module conv_window_addr_gen #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int K          = 5,
    parameter int STRIDE     = 1,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [5:0]            tap,
    output logic                  valid,
    input  logic                  ready,
    output logic                  tap_last,
    output logic                  frame_last,
    output logic                  pad
);

`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam int P = (K - 1) / 2;
`else
    localparam int P = 0;
`endif
    localparam int OUT_W = (IMG_W + 2 * P - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H + 2 * P - K) / STRIDE + 1;
    localparam int IW    = ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_next;

    logic [2:0]    kc, kr, kc_ld, kr_ld;
    logic [IW-1:0] ocol, orow, ocol_ld, orow_ld;
    logic          kc_end, kr_end, ocol_end, orow_end;
    logic          fire, load;

    logic [ADDR_WIDTH-1:0] addr_ld;
    logic [5:0]            tap_ld;
    logic                  tap_last_ld, frame_last_ld, pad_ld;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (ready && frame_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == S_RUN);
        valid = (state == S_RUN);
        done  = (state == S_DONE);
    end

    always_comb begin
        fire = (state == S_RUN) && ready;
        load = ((state == S_IDLE) && start) || fire;
    end

    // Indices of the beat that will be presented after this edge; IDLE starts from all zeros.
    always_comb begin
        kc_end   = (kc == 3'(K - 1));
        kr_end   = (kr == 3'(K - 1));
        ocol_end = (ocol == IW'(OUT_W - 1));
        orow_end = (orow == IW'(OUT_H - 1));
        kc_ld    = kc;
        kr_ld    = kr;
        ocol_ld  = ocol;
        orow_ld  = orow;
        if (state == S_IDLE) begin
            kc_ld   = '0;
            kr_ld   = '0;
            ocol_ld = '0;
            orow_ld = '0;
        end else begin
            kc_ld = kc_end ? '0 : kc + 3'd1;
            if (kc_end)
                kr_ld = kr_end ? '0 : kr + 3'd1;
            if (kc_end && kr_end)
                ocol_ld = ocol_end ? '0 : ocol + IW'(1);
            if (kc_end && kr_end && ocol_end)
                orow_ld = orow_end ? '0 : orow + IW'(1);
        end
    end

`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam int RW = ADDR_WIDTH + 2;
    localparam logic signed [RW-1:0] H_S = RW'(IMG_H);
    localparam logic signed [RW-1:0] W_S = RW'(IMG_W);
    logic signed [RW-1:0] row_s, col_s;

    // Signed position so taps hanging off the top/left edge show up as negative.
    always_comb begin
        row_s   = RW'(orow_ld) * RW'(STRIDE) + RW'(kr_ld) - RW'(P);
        col_s   = RW'(ocol_ld) * RW'(STRIDE) + RW'(kc_ld) - RW'(P);
        pad_ld  = (row_s < 0) || (row_s >= H_S) || (col_s < 0) || (col_s >= W_S);
        addr_ld = pad_ld ? '0 : ADDR_WIDTH'(row_s * W_S + col_s);
    end
`else
    logic [ADDR_WIDTH-1:0] row_u, col_u;

    always_comb begin
        row_u   = ADDR_WIDTH'(orow_ld) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(kr_ld);
        col_u   = ADDR_WIDTH'(ocol_ld) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(kc_ld);
        addr_ld = row_u * ADDR_WIDTH'(IMG_W) + col_u;
        pad_ld  = 1'b0;
    end
`endif

    always_comb begin
        tap_ld        = 6'(kr_ld) * 6'(K) + 6'(kc_ld);
        tap_last_ld   = (kr_ld == 3'(K - 1)) && (kc_ld == 3'(K - 1));
        frame_last_ld = tap_last_ld && (ocol_ld == IW'(OUT_W - 1)) && (orow_ld == IW'(OUT_H - 1));
    end

    // Outputs only change on a load, so they hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            kc         <= '0;
            kr         <= '0;
            ocol       <= '0;
            orow       <= '0;
            addr       <= '0;
            tap        <= '0;
            tap_last   <= 1'b0;
            frame_last <= 1'b0;
            pad        <= 1'b0;
        end else if (load) begin
            kc         <= kc_ld;
            kr         <= kr_ld;
            ocol       <= ocol_ld;
            orow       <= orow_ld;
            addr       <= addr_ld;
            tap        <= tap_ld;
            tap_last   <= tap_last_ld;
            frame_last <= frame_last_ld;
            pad        <= pad_ld;
        end
    end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Self-checking bench for conv_window_addr_gen against an index-arithmetic reference model.
// Honours CONV_WINDOW_ZERO_PAD_EN the same way the design does.
module tb_conv_window_addr_gen;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 5;
    localparam int STRIDE = 1;
    localparam int AW     = 10;
`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam int P  = (K - 1) / 2;
    localparam int P2 = (2 - 1) / 2;
`else
    localparam int P  = 0;
    localparam int P2 = 0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [5:0]    tap;
        logic          tap_last;
        logic          frame_last;
        logic          pad;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic busy, done, valid, tap_last, frame_last, pad;
    logic [AW-1:0] addr;
    logic [5:0] tap;

    logic start_s = 1'b0;
    logic ready_s = 1'b1;
    logic busy_s, done_s, valid_s, tap_last_s, frame_last_s, pad_s;
    logic [AW-1:0] addr_s;
    logic [5:0] tap_s;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    conv_window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(STRIDE), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .addr(addr), .tap(tap),
        .valid(valid), .ready(ready), .tap_last(tap_last), .frame_last(frame_last), .pad(pad)
    );

    conv_window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(2), .STRIDE(2), .ADDR_WIDTH(AW)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .addr(addr_s), .tap(tap_s),
        .valid(valid_s), .ready(ready_s), .tap_last(tap_last_s), .frame_last(frame_last_s), .pad(pad_s)
    );

    function automatic int frame_len(int iw, int ih, int k, int s, int p);
        return ((iw + 2 * p - k) / s + 1) * ((ih + 2 * p - k) / s + 1) * k * k;
    endfunction

    // Beat n of a frame, decomposed directly from its position in the scan order.
    function automatic beat_t model_beat(int iw, int ih, int k, int s, int p, int n);
        beat_t b;
        int ow, kk, t, w, ocol, orow, row, col;
        ow   = (iw + 2 * p - k) / s + 1;
        kk   = k * k;
        t    = n % kk;
        w    = n / kk;
        ocol = w % ow;
        orow = w / ow;
        row  = orow * s + t / k - p;
        col  = ocol * s + t % k - p;
        b.pad        = (row < 0) || (row >= ih) || (col < 0) || (col >= iw);
        b.addr       = b.pad ? '0 : AW'(row * iw + col);
        b.tap        = 6'(t);
        b.tap_last   = (t == kk - 1);
        b.frame_last = (n == frame_len(iw, ih, k, s, p) - 1);
        return b;
    endfunction

    function automatic beat_t exp_main(int n);
        return model_beat(IMG_W, IMG_H, K, STRIDE, P, n);
    endfunction

    // Monitor on the falling edge: accepted beats, done pulses, stability under stall.
    beat_t beats[$];
    beat_t cur, held;
    int done_cnt = 0, hold_err = 0, cyc = 0, fl_cyc = -100, done_cyc = -200;
    bit stalled_prev = 1'b0;

    assign cur = {addr, tap, tap_last, frame_last, pad};

    always @(negedge clk) begin
        cyc++;
        if (valid && ready) begin
            beats.push_back(cur);
            if (frame_last) fl_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stalled_prev && valid && (cur !== held)) hold_err++;
        stalled_prev = valid && !ready;
        held = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_until_done(input int ready_pct, input int restart_at, output bit timed_out);
        bit restarted = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 60000; c++) begin
            ready = (int'($urandom_range(0, 99)) < ready_pct);
            start = !restarted && (beats.size() == restart_at);
            if (start) restarted = 1'b1;
            tick();
            start = 1'b0;
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_checks++; if (addr !== '0) $display("[TB] FAIL reset_addr got %0d want 0", addr); else n_pass++;
        n_checks++; if (tap !== '0) $display("[TB] FAIL reset_tap got %0d want 0", tap); else n_pass++;
        n_checks++; if (tap_last !== 1'b0) $display("[TB] FAIL reset_tap_last got %b want 0", tap_last); else n_pass++;
        n_checks++; if (frame_last !== 1'b0) $display("[TB] FAIL reset_frame_last got %b want 0", frame_last); else n_pass++;
        n_checks++; if (pad !== 1'b0) $display("[TB] FAIL reset_pad got %b want 0", pad); else n_pass++;
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL idle_no_start_valid got %b want 0", valid); else n_pass++;
    endtask

    task automatic test_basic();
        bit to;
        int bad = 0;
        beat_t e;
        beats.delete();
        done_cnt = 0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = exp_main(0);
        n_checks++; if (valid !== 1'b1) $display("[TB] FAIL basic_latency_valid got %b want 1", valid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (addr !== e.addr) $display("[TB] FAIL basic_first_addr got %0d want %0d", addr, e.addr); else n_pass++;
        drive_until_done(100, -1, to);
        n_checks++; if (to) $display("[TB] FAIL basic_timeout got timeout want done"); else n_pass++;
        for (int i = 0; i < beats.size(); i++) begin
            e = exp_main(i);
            if (beats[i] !== e) begin
                if (bad == 0)
                    $display("[TB] basic first divergence beat %0d: addr=%0d tap=%0d tl=%b fl=%b pad=%b, model addr=%0d tap=%0d tl=%b fl=%b pad=%b",
                             i, beats[i].addr, beats[i].tap, beats[i].tap_last, beats[i].frame_last, beats[i].pad,
                             e.addr, e.tap, e.tap_last, e.frame_last, e.pad);
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("[TB] FAIL basic_beats got %0d wrong beats want 0", bad); else n_pass++;
        n_checks++; if (beats.size() != FRAME_N()) $display("[TB] FAIL basic_count got %0d want %0d", beats.size(), FRAME_N()); else n_pass++;
        if (beats.size() > 25) begin
            e = exp_main(25);
            n_checks++; if (beats[24].tap_last !== 1'b1) $display("[TB] FAIL basic_tap24_last got %b want 1", beats[24].tap_last); else n_pass++;
            n_checks++; if (beats[25].addr !== e.addr) $display("[TB] FAIL basic_beat25_addr got %0d want %0d", beats[25].addr, e.addr); else n_pass++;
        end
        n_checks++; if (done_cyc - fl_cyc != 1) $display("[TB] FAIL basic_done_timing got %0d cycles want 1", done_cyc - fl_cyc); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("[TB] FAIL basic_done_count got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0 || valid !== 1'b0) $display("[TB] FAIL basic_idle_after got busy=%b valid=%b want 0/0", busy, valid); else n_pass++;
    endtask

    function automatic int FRAME_N();
        return frame_len(IMG_W, IMG_H, K, STRIDE, P);
    endfunction

    task automatic test_backpressure();
        bit to;
        int bad = 0;
        beat_t e;
        beats.delete();
        done_cnt = 0;
        hold_err = 0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && beats.size() < 7; c++) tick();
        ready = 1'b0;
        e = exp_main(7);
        for (int s = 0; s < 3; s++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || addr !== e.addr || tap !== e.tap)
                $display("[TB] FAIL stall_hold_%0d got valid=%b addr=%0d tap=%0d want 1/%0d/%0d", s, valid, addr, tap, e.addr, e.tap);
            else n_pass++;
        end
        n_checks++; if (beats.size() != 7) $display("[TB] FAIL stall_accepted got %0d want 7", beats.size()); else n_pass++;
        drive_until_done(70, -1, to);
        n_checks++; if (to) $display("[TB] FAIL bp_timeout got timeout want done"); else n_pass++;
        for (int i = 0; i < beats.size(); i++) begin
            e = exp_main(i);
            if (beats[i] !== e) begin
                if (bad == 0) $display("[TB] bp first divergence beat %0d: addr=%0d want %0d", i, beats[i].addr, e.addr);
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("[TB] FAIL bp_beats got %0d wrong beats want 0", bad); else n_pass++;
        n_checks++; if (beats.size() != FRAME_N()) $display("[TB] FAIL bp_count got %0d want %0d", beats.size(), FRAME_N()); else n_pass++;
        n_checks++; if (hold_err != 0) $display("[TB] FAIL bp_hold_stable got %0d changes want 0", hold_err); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("[TB] FAIL bp_done_count got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        bit to;
        int bad = 0;
        beats.delete();
        done_cnt = 0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_until_done(100, 100, to);
        n_checks++; if (to) $display("[TB] FAIL busy_timeout got timeout want done"); else n_pass++;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i] !== exp_main(i)) bad++;
        n_checks++; if (bad != 0) $display("[TB] FAIL busy_beats got %0d wrong beats want 0", bad); else n_pass++;
        n_checks++; if (beats.size() != FRAME_N()) $display("[TB] FAIL busy_count got %0d want %0d", beats.size(), FRAME_N()); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("[TB] FAIL busy_done_count got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back_and_reset();
        int bad = 0;
        beat_t e;
        e = exp_main(0);
        // Starts in the IDLE cycle right after the previous frame's done.
        beats.delete();
        done_cnt = 0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (valid !== 1'b1 || addr !== e.addr) $display("[TB] FAIL b2b_start got valid=%b addr=%0d want 1/%0d", valid, addr, e.addr); else n_pass++;
        for (int c = 0; c < 6000 && beats.size() < 5000; c++) tick();
        rst = 1'b1;
        tick();
        n_checks++; if (valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL midreset_state got valid=%b busy=%b want 0/0", valid, busy); else n_pass++;
        n_checks++; if (addr !== '0 || tap !== '0) $display("[TB] FAIL midreset_outputs got addr=%0d tap=%0d want 0/0", addr, tap); else n_pass++;
        rst = 1'b0;
        done_cnt = 0;
        repeat (10) tick();
        n_checks++; if (done_cnt != 0) $display("[TB] FAIL midreset_no_done got %0d pulses want 0", done_cnt); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL midreset_idle got valid=%b want 0", valid); else n_pass++;
        beats.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (valid !== 1'b1 || addr !== e.addr || tap !== 6'd0) $display("[TB] FAIL restart_first got valid=%b addr=%0d tap=%0d want 1/%0d/0", valid, addr, tap, e.addr); else n_pass++;
        repeat (30) tick();
        for (int i = 0; i < beats.size(); i++)
            if (beats[i] !== exp_main(i)) bad++;
        n_checks++; if (bad != 0 || beats.size() != 30) $display("[TB] FAIL restart_beats got %0d wrong of %0d want 0 of 30", bad, beats.size()); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stride();
        int idx = 0, bad = 0, w1_addr = -1, w14_addr = -1;
        int n2 = frame_len(IMG_W, IMG_H, 2, 2, P2);
        bit got_done = 1'b0;
        beat_t e, b;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!valid_s) begin
                got_done = done_s;
                break;
            end
            b = {addr_s, tap_s, tap_last_s, frame_last_s, pad_s};
            e = model_beat(IMG_W, IMG_H, 2, 2, P2, idx);
            if (b !== e) begin
                if (bad == 0) $display("[TB] stride first divergence beat %0d: addr=%0d want %0d", idx, addr_s, e.addr);
                bad++;
            end
            if (idx == 4) w1_addr = int'(addr_s);
            if (idx == 56) w14_addr = int'(addr_s);
            idx++;
            tick();
        end
        n_checks++; if (idx != n2) $display("[TB] FAIL stride_count got %0d want %0d", idx, n2); else n_pass++;
        n_checks++; if (bad != 0) $display("[TB] FAIL stride_beats got %0d wrong beats want 0", bad); else n_pass++;
        n_checks++; if (w1_addr != 2) $display("[TB] FAIL stride_window1 got %0d want 2", w1_addr); else n_pass++;
        n_checks++; if (w14_addr != 56) $display("[TB] FAIL stride_window14 got %0d want 56", w14_addr); else n_pass++;
        n_checks++; if (!got_done) $display("[TB] FAIL stride_done got %b want 1", got_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back_and_reset();
        test_stride();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
